// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole player side.
package whack_pkg;

    localparam int unsigned NUM_MOLES               = 3;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;
    localparam int unsigned SCORE_W_DEFAULT         = 8;
    localparam logic [SCORE_W_DEFAULT-1:0] SCORE_MAX = '1;

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StWaitClear,
        StWaitRelease
    } judge_state_e;

endpackage

// File: rtl/hit_judge_if.sv
// Player-side bundle between the board I/O, the mole display and the judge.
interface hit_judge_if import whack_pkg::*; #(
    parameter int unsigned SCORE_W = SCORE_W_DEFAULT
) ();

    logic                 game;
    logic [NUM_MOLES-1:0] button;
    logic [NUM_MOLES-1:0] mole;
    logic                 turnoff;
    logic                 hit;
    logic                 miss;
    logic [SCORE_W-1:0]   score;

    modport master (
        output game, button, mole,
        input  turnoff, hit, miss, score
    );

    modport slave (
        input  game, button, mole,
        output turnoff, hit, miss, score
    );

endinterface

// File: rtl/button_debouncer.sv
// One button: 2-flop synchronizer, stability counter and registered rising-edge event.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic level,
    output logic press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             synced;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             level_prev_q;
    logic             press_q;
    logic [1:0]       fill_q;
    logic             primed_q;

    assign synced = sync_q[1];

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clock) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[0], button};
    end

    // Count consecutive cycles the synced value differs from the accepted level.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (synced == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = synced;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Debounce state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
        end
    end

    // A button held through reset must be seen released before it may fire again:
    // wait for the synchronizer to refill, then require a low synced level.
    always_ff @(posedge clock) begin
        if (reset) begin
            fill_q   <= '0;
            primed_q <= 1'b0;
        end else begin
            if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
            if (fill_q == 2'd2 && !synced) primed_q <= 1'b1;
        end
    end

    // Registered one-cycle press event on a 0->1 debounced transition.
    always_ff @(posedge clock) begin
        if (reset) press_q <= 1'b0;
        else       press_q <= level_q & ~level_prev_q & primed_q;
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/hit_judge.sv
// Debounces the mole buttons, judges presses against the lit mole and keeps the score.
module hit_judge import whack_pkg::*; #(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned SCORE_W         = SCORE_W_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    hit_judge_if.slave  bus
);

    localparam logic [SCORE_W-1:0] SCORE_TOP = {SCORE_W{1'b1}};

    logic [NUM_MOLES-1:0] level;
    logic [NUM_MOLES-1:0] press;

    judge_state_e       state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               turnoff_q, turnoff_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;

    logic any_press;
    logic mole_lit;
    logic is_hit;

    for (genvar i = 0; i < NUM_MOLES; i++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clock (clock),
            .reset (reset),
            .button(bus.button[i]),
            .level (level[i]),
            .press (press[i])
        );
    end

    assign any_press = |press;
    assign mole_lit  = |bus.mole;
    assign is_hit    = |(press & bus.mole);

    // Next state, score update and pulse generation.
    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        turnoff_d = 1'b0;
        hit_d     = 1'b0;
        miss_d    = 1'b0;
        if (!bus.game) begin
            state_d = StIdle;
            score_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    score_d = '0;
                    state_d = StArmed;
                end
                StArmed: begin
                    // Presses with no mole lit are ignored entirely.
                    if (any_press && mole_lit) begin
                        if (is_hit) begin
                            turnoff_d = 1'b1;
                            hit_d     = 1'b1;
                            if (score_q != SCORE_TOP) score_d = score_q + SCORE_W'(1);
                            state_d = StWaitClear;
                        end else begin
                            miss_d = 1'b1;
                            if (score_q != '0) score_d = score_q - SCORE_W'(1);
                            state_d = StWaitRelease;
                        end
                    end
                end
                StWaitClear: begin
                    if (!mole_lit) state_d = StWaitRelease;
                end
                StWaitRelease: begin
                    if (level == '0) state_d = StArmed;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Registered score and result pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            score_q   <= '0;
            turnoff_q <= 1'b0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
        end else begin
            score_q   <= score_d;
            turnoff_q <= turnoff_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
        end
    end

    assign bus.turnoff = turnoff_q;
    assign bus.hit     = hit_q;
    assign bus.miss    = miss_q;
    assign bus.score   = score_q;

endmodule

// File: tb/tb_hit_judge.sv
// Directed bench for hit_judge with a short debounce window.
module tb_hit_judge;

    localparam int unsigned DEB  = 4;
    localparam int unsigned SW   = 8;
    localparam int          HOLD = 10;
    localparam int          GAP  = 10;

    logic clock = 1'b0;
    logic reset = 1'b1;

    hit_judge_if #(.SCORE_W(SW)) bus ();

    hit_judge #(
        .DEBOUNCE_CYCLES(DEB),
        .SCORE_W        (SW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int n_vec  = 0;
    int n_bad  = 0;
    int cnt_hit;
    int cnt_miss;
    int cnt_turn;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        cnt_hit  = 0;
        cnt_miss = 0;
        cnt_turn = 0;
    endtask

    // Advance one clock and tally any pulses seen.
    task automatic step();
        @(posedge clock);
        #1;
        if (bus.turnoff === 1'b1) cnt_turn++;
        if (bus.hit === 1'b1)     cnt_hit++;
        if (bus.miss === 1'b1)    cnt_miss++;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Light a mole, press, then release everything and let the judge rearm.
    task automatic tap(input logic [2:0] b, input logic [2:0] m);
        clear_counts();
        bus.mole   = m;
        bus.button = b;
        wait_cycles(HOLD);
        bus.button = '0;
        bus.mole   = '0;
        wait_cycles(GAP);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bus.game   = 1'b0;
        bus.button = '0;
        bus.mole   = '0;
        clear_counts();
        wait_cycles(3);
        check("rst score", bus.score, 0);
        check("rst turnoff", bus.turnoff, 0);
        check("rst hit", bus.hit, 0);
        check("rst miss", bus.miss, 0);
        reset    = 1'b0;
        bus.game = 1'b1;
        wait_cycles(4);

        // Latency: pulse lands on the 8th edge after the raw rise (cycle DEB+3).
        clear_counts();
        bus.mole   = 3'b010;
        bus.button = 3'b010;
        wait_cycles(7);
        check("lat early", cnt_turn + cnt_hit + cnt_miss, 0);
        step();
        check("lat turnoff", bus.turnoff, 1);
        check("lat hit", bus.hit, 1);
        check("lat score", bus.score, 1);
        step();
        check("lat turnoff width", bus.turnoff, 0);
        check("lat one pulse", cnt_turn, 1);
        bus.button = '0;
        bus.mole   = '0;
        wait_cycles(GAP);
        tap(3'b001, 3'b001);
        check("rearm hit", cnt_hit, 1);
        check("rearm score", bus.score, 2);
        repeat (3) tap(3'b001, 3'b001);
        check("score five", bus.score, 5);

        // Wrong button, then extra presses while still held.
        clear_counts();
        bus.mole   = 3'b001;
        bus.button = 3'b100;
        wait_cycles(HOLD);
        check("miss pulse", cnt_miss, 1);
        check("miss score", bus.score, 4);
        bus.button = 3'b101;
        wait_cycles(HOLD);
        check("held ignored hit", cnt_hit, 0);
        check("held ignored miss", cnt_miss, 1);
        check("held score", bus.score, 4);
        bus.button = '0;
        bus.mole   = '0;
        wait_cycles(GAP);
        tap(3'b100, 3'b001);
        check("repress miss", cnt_miss, 1);
        check("repress score", bus.score, 3);

        // Bounce shorter than the window.
        clear_counts();
        bus.mole = 3'b001;
        for (int i = 0; i < 10; i++) begin
            bus.button = 3'b001;
            wait_cycles(2);
            bus.button = 3'b000;
            wait_cycles(2);
        end
        wait_cycles(GAP);
        check("bounce pulses", cnt_turn + cnt_hit + cnt_miss, 0);
        check("bounce score", bus.score, 3);
        bus.mole = '0;

        // No mole lit, then misses down to and at zero.
        tap(3'b001, 3'b000);
        check("no mole pulses", cnt_turn + cnt_hit + cnt_miss, 0);
        check("no mole score", bus.score, 3);
        repeat (3) tap(3'b100, 3'b001);
        check("down to zero", bus.score, 0);
        tap(3'b010, 3'b001);
        check("floor miss", cnt_miss, 1);
        check("floor score", bus.score, 0);

        // Two wrong buttons together count once.
        tap(3'b110, 3'b001);
        check("dual wrong miss", cnt_miss, 1);
        // Right and wrong together count as one hit.
        tap(3'b011, 3'b001);
        check("dual hit", cnt_hit, 1);
        check("dual hit miss", cnt_miss, 0);
        check("dual score", bus.score, 1);

        // Saturation.
        repeat (253) tap(3'b001, 3'b001);
        check("sat 254", bus.score, 254);
        tap(3'b001, 3'b001);
        check("sat 255", bus.score, 255);
        tap(3'b001, 3'b001);
        check("sat hold hit", cnt_hit, 1);
        check("sat hold", bus.score, 255);

        // Game drop mid-WAIT_CLEAR.
        bus.game = 1'b0;
        step();
        check("game clr", bus.score, 0);
        bus.game = 1'b1;
        repeat (8) tap(3'b010, 3'b010);
        clear_counts();
        bus.mole   = 3'b010;
        bus.button = 3'b010;
        wait_cycles(HOLD);
        check("nine score", bus.score, 9);
        bus.game = 1'b0;
        step();
        check("drop score", bus.score, 0);
        bus.game = 1'b1;
        clear_counts();
        wait_cycles(HOLD);
        check("reentry no fire", cnt_turn + cnt_hit + cnt_miss, 0);
        bus.button = '0;
        bus.mole   = '0;
        wait_cycles(GAP);
        tap(3'b010, 3'b010);
        check("reentry hit", cnt_hit, 1);
        check("reentry score", bus.score, 1);

        // Reset while a button is held.
        bus.mole   = 3'b001;
        bus.button = 3'b001;
        wait_cycles(HOLD);
        check("pre reset score", bus.score, 2);
        reset = 1'b1;
        step();
        check("mid rst score", bus.score, 0);
        check("mid rst turnoff", bus.turnoff, 0);
        check("mid rst hit", bus.hit, 0);
        check("mid rst miss", bus.miss, 0);
        step();
        reset = 1'b0;
        clear_counts();
        wait_cycles(20);
        check("held thru rst", cnt_turn + cnt_hit + cnt_miss, 0);
        check("held thru rst score", bus.score, 0);
        bus.button = '0;
        bus.mole   = '0;
        wait_cycles(GAP);
        tap(3'b001, 3'b001);
        check("post rst hit", cnt_hit, 1);
        check("post rst score", bus.score, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/hit_judge.md
Name: hit_judge

Overview:
- Player-side counterpart to the mole display controller.
- Debounces the three active-high push buttons and judges each press against the currently lit mole.
- On a hit, returns a one-cycle turnoff pulse to the display controller and updates the score, which drives the HEX score decoders.
- Fully synchronous to one clock; replaces edge-triggered button logic.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a button level (10 ms at 50 MHz)
SCORE_W, 8, score width in bits
NUM_MOLES, 3, number of moles/buttons (fixed at 3 for this game)

Ports:
clock  input  1  system clock (CLOCK_50 at top)
reset  input  1  synchronous, active-high reset
game  input  1  1 = game running; 0 = clear score and idle
button  input  3  raw button levels, active-high (KEY already inverted at top), asynchronous
mole  input  3  lit-mole vector from display controller, at most one bit high
turnoff  output  1  one-cycle pulse on a correct hit; consumed by the display controller
hit  output  1  one-cycle pulse, same cycle as turnoff
miss  output  1  one-cycle pulse on a wrong press while a mole is lit
score  output  SCORE_W  current score, saturating

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: turnoff=0, hit=0, miss=0, score=0, FSM=IDLE, synchronizers=0, debounced levels=0, debounce counters=0.
- Synchronizer: each button bit passes through a 2-flop synchronizer.
- Debounce:
  - Each button has a counter, reset to 0 whenever the synced value equals the debounced level.
  - The debounced level takes the synced value when the counter reaches DEBOUNCE_CYCLES-1 with the synced value still differing.
  - A press event is a registered 0->1 transition of the debounced level, lasting one cycle.
- Latency: raw button rising and held steady from cycle 0 -> press event at cycle DEBOUNCE_CYCLES+2 -> turnoff/hit/miss high at cycle DEBOUNCE_CYCLES+3, for exactly one cycle.
- Glitches: any bounce shorter than DEBOUNCE_CYCLES produces no event.
- FSM states:
  - IDLE: score held at 0, no pulses. Go to ARMED when game=1.
  - ARMED, when any press event occurs:
    - mole==0: ignore the press, stay ARMED.
    - (press & mole)!=0: hit. Pulse turnoff and hit, score+1 saturating at 2^SCORE_W-1, go to WAIT_CLEAR.
    - Otherwise: miss. Pulse miss, score-1 with floor 0 (score 0 stays 0, miss still pulses), go to WAIT_RELEASE.
  - WAIT_CLEAR: ignore all presses; go to WAIT_RELEASE once mole==0.
  - WAIT_RELEASE: ignore all presses; go to ARMED once all debounced levels are 0.
- Simultaneous presses in the same cycle:
  - Any pressed bit matching the lit mole counts as one hit (+1 only).
  - Two wrong buttons pressed together count as one miss.
- game=0 in any state:
  - Next cycle: state=IDLE, score=0, pulses suppressed.
  - Debounce logic keeps running, so held buttons do not re-fire on game re-entry.
- reset mid-operation overrides game and everything else.
- Width rule: score arithmetic is SCORE_W-bit unsigned with explicit saturation; no wrap-around.

Decomposition:
- Shared package whack_pkg holds:
  - judge state enum: IDLE, ARMED, WAIT_CLEAR, WAIT_RELEASE.
  - NUM_MOLES=3.
  - default DEBOUNCE_CYCLES.
  - SCORE_MAX constant.
- Sub-module button_debouncer (synchronizer + counter + rising-edge detect), instantiated NUM_MOLES times.
- hit_judge contains the FSM and the score logic.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, game=1, mole=3'b010, button[1] raised and held -> turnoff and hit high exactly 7 cycles later for 1 cycle; score 0->1. Release button, drop mole -> FSM returns to ARMED.
- mole=3'b001, score=5, press button[2] -> miss pulse, score=4. A second press while button[2] is still held is ignored; after release and re-press -> score=3.
- Button[0] toggled every 2 cycles for 40 cycles with mole=3'b001 -> no turnoff, hit or miss; score unchanged.
- Press with mole=0 -> no pulses, score unchanged. Miss at score=0 -> miss pulses, score stays 0.
- Score forced to 254 via 254 hits, then 2 more hits -> score 255, then stays 255.
- Score=9, drop game for 1 cycle mid-WAIT_CLEAR -> score=0, state IDLE. Assert reset while button is held -> all outputs 0, and no press event until the button is released and pressed again.
